bcd_counter_2digit: RTL and testbench
=====================================

Name: bcd_counter_2digit

Overview:
- Two-digit BCD up/down counter with a built-in clock prescaler.
- Sits directly upstream of the per-digit 4-bit-to-7-segment decoders: BCD1 drives the tens display and BCD0 drives the ones display.
- Counts 00..99 at a rate set by a parameter.
- Supports synchronous parallel load from switches.
- Provides a one-cycle update strobe and a wrap (carry/borrow) pulse for cascading.

Parameters:
- TICK_DIV, 50000000, number of Clock cycles per count step. Legal range is 1 or more. The prescaler width is ceil(log2(TICK_DIV)), minimum 1 bit.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Resetn  in  1  synchronous, active-low reset.
- En  in  1  count enable. When low, the prescaler and the count both hold.
- Up  in  1  direction: 1 = increment, 0 = decrement. Sampled on each step edge.
- Load  in  1  synchronous parallel load strobe.
- D  in  8  load value: D[7:4] = tens digit, D[3:0] = ones digit.
- BCD1  out  4  tens digit, registered, range 0..9.
- BCD0  out  4  ones digit, registered, range 0..9.
- Tick  out  1  one-cycle pulse, high in the cycle in which a newly stepped count is first visible.
- Carry  out  1  one-cycle pulse, high in the same cycle as Tick when the step wrapped (99->00 up, 00->99 down).

Behaviour:
- Reset (Resetn=0 at an edge): BCD1=0, BCD0=0, Tick=0, Carry=0, prescaler=0. Reset has priority over Load and En, and a reset mid-count discards any partial prescale.
- Priority per edge: Resetn, then Load, then step, then hold.
- Load (Resetn=1, Load=1):
  - BCD1 <= min(D[7:4],9); BCD0 <= min(D[3:0],9). Non-BCD nibbles 10..15 clamp to 9.
  - Prescaler <= 0; Tick <= 0; Carry <= 0.
  - Load works regardless of En. New digits are visible the cycle after the edge.
- Prescaler (Resetn=1, Load=0):
  - If En=1 and prescaler = TICK_DIV-1: prescaler <= 0 and a step occurs on this edge.
  - If En=1 otherwise: prescaler <= prescaler+1 and there is no step.
  - If En=0: prescaler holds and there is no step.
  - With TICK_DIV=1, a step occurs on every edge with En=1.
- Step, up (Up=1):
  - If BCD0<9: BCD0+1.
  - Else BCD0 <= 0, and: if BCD1<9 then BCD1+1; else BCD1 <= 0 and Carry <= 1.
- Step, down (Up=0):
  - If BCD0>0: BCD0-1.
  - Else BCD0 <= 9, and: if BCD1>0 then BCD1-1; else BCD1 <= 9 and Carry <= 1.
- Tick and Carry:
  - Tick <= 1 on every step edge; Tick <= 0 on every other edge.
  - Carry <= 0 on every edge except a wrapping step.
  - Both are therefore exactly one cycle wide and are never high without a step.
  - Counting latency: the first step occurs TICK_DIV enabled cycles after reset or load. Consecutive steps are TICK_DIV enabled cycles apart.
- Direction change: Up is sampled only on the step edge. Toggling Up between steps has no effect on the prescaler.
- En deassert mid-period: the prescaler freezes. On re-enable it resumes from the frozen value, so no step is lost and none is duplicated.
- Load coinciding with a would-be step edge: Load wins; no step, no Tick, no Carry; prescaler restarts from 0.
- Invariant: BCD1 and BCD0 are never greater than 9 in any cycle.

Test Plan:
- TICK_DIV=4. Reset, then En=1, Up=1 for 16 cycles -> BCD1:BCD0 = 00,01,02,03,04, with Tick high exactly at cycles 4, 8, 12 and 16, and Carry=0 throughout.
- TICK_DIV=1. Load D=8'h98, then En=1, Up=1 -> 99, then 00 with Tick=1 and Carry=1 on that cycle only, then 01 with Carry=0.
- TICK_DIV=1. Load D=8'h01, then En=1, Up=0 -> 00, then 99 with Carry=1, then 98. Separately, Load 8'h10 and step down -> 09 (ones-digit borrow into tens).
- TICK_DIV=4. En=1 for 2 cycles, En=0 for 5 cycles, En=1 for 2 cycles -> exactly one step (00->01), occurring at the 4th enabled cycle; no Tick while En=0.
- TICK_DIV=4. Load D=8'hFA -> 99 (both nibbles clamped). Load asserted on the cycle the prescaler is at 3 -> count equals the loaded value, Tick=0, and the next step comes 4 enabled cycles later.
- TICK_DIV=4. Count to 37, then Resetn=0 for one edge with Load=1 and D=8'h55 -> 00, Tick=0, Carry=0. After release, the first step comes 4 cycles later.

Source files
------------

// File: rtl/bcd_counter_2digit.sv
// rtl/bcd_counter_2digit.sv - two-digit BCD up/down counter with clock prescaler
//
// Purpose:
//    Counts 00..99 in BCD, one step every TICK_DIV enabled clock cycles.
//    Feeds per-digit 7-segment decoders (o_bcd1 = tens, o_bcd0 = ones).
//    Supports a synchronous parallel load with clamping of non-BCD nibbles,
//    and emits a one-cycle update strobe plus a wrap pulse for cascading.
//
// Parameters:
//    TICK_DIV  clock cycles per count step (>= 1)
//
// Ports:
//    i_clock   in   1  system clock, rising edge
//    i_resetn  in   1  synchronous active-low reset
//    i_en      in   1  count enable; low freezes prescaler and count
//    i_up      in   1  1 = increment, 0 = decrement (sampled on step edge)
//    i_load    in   1  synchronous parallel load strobe
//    i_d       in   8  load value: [7:4] tens, [3:0] ones
//    o_bcd1    out  4  tens digit, registered, 0..9
//    o_bcd0    out  4  ones digit, registered, 0..9
//    o_tick    out  1  high in the cycle a newly stepped count is first visible
//    o_carry   out  1  high with o_tick when the step wrapped (99->00 / 00->99)

module bcd_counter_2digit #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       i_clock,
   input  logic       i_resetn,
   input  logic       i_en,
   input  logic       i_up,
   input  logic       i_load,
   input  logic [7:0] i_d,
   output logic [3:0] o_bcd1,
   output logic [3:0] o_bcd0,
   output logic       o_tick,
   output logic       o_carry
);

   // A single-cycle divider still needs a 1-bit register to keep widths legal;
   // with TICK_DIV=1 it stays at 0 and every enabled edge is a step.
   localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] r_presc;
   logic [3:0]    r_bcd1;
   logic [3:0]    r_bcd0;
   logic          r_tick;
   logic          r_carry;

   logic          w_step;
   logic [PW-1:0] w_presc_inc;
   logic [3:0]    w_nxt1;
   logic [3:0]    w_nxt0;
   logic          w_wrap;
   logic [3:0]    w_ld1;
   logic [3:0]    w_ld0;

   function automatic logic [3:0] clamp9(input logic [3:0] n);
      return (n > 4'd9) ? 4'd9 : n;
   endfunction

   assign w_step      = i_en && (r_presc == PRESC_LAST);
   assign w_presc_inc = r_presc + PW'(1);
   assign w_ld1       = clamp9(i_d[7:4]);
   assign w_ld0       = clamp9(i_d[3:0]);

   // Next count for a step in the sampled direction; the tens digit only
   // moves when the ones digit rolls over, and a tens rollover is the wrap.
   always_comb begin
      w_nxt1 = r_bcd1;
      w_nxt0 = r_bcd0;
      w_wrap = 1'b0;
      if (i_up) begin
         if (r_bcd0 < 4'd9) begin
            w_nxt0 = r_bcd0 + 4'd1;
         end else begin
            w_nxt0 = 4'd0;
            if (r_bcd1 < 4'd9) begin
               w_nxt1 = r_bcd1 + 4'd1;
            end else begin
               w_nxt1 = 4'd0;
               w_wrap = 1'b1;
            end
         end
      end else begin
         if (r_bcd0 > 4'd0) begin
            w_nxt0 = r_bcd0 - 4'd1;
         end else begin
            w_nxt0 = 4'd9;
            if (r_bcd1 > 4'd0) begin
               w_nxt1 = r_bcd1 - 4'd1;
            end else begin
               w_nxt1 = 4'd9;
               w_wrap = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_resetn) begin
         r_presc <= '0;
         r_bcd1  <= 4'd0;
         r_bcd0  <= 4'd0;
         r_tick  <= 1'b0;
         r_carry <= 1'b0;
      end else if (i_load) begin
         // Load restarts the prescale period, so a would-be step is dropped.
         r_presc <= '0;
         r_bcd1  <= w_ld1;
         r_bcd0  <= w_ld0;
         r_tick  <= 1'b0;
         r_carry <= 1'b0;
      end else begin
         r_tick  <= w_step;
         r_carry <= w_step && w_wrap;
         if (i_en) begin
            r_presc <= w_step ? '0 : w_presc_inc;
         end
         if (w_step) begin
            r_bcd1 <= w_nxt1;
            r_bcd0 <= w_nxt0;
         end
      end
   end

   assign o_bcd1  = r_bcd1;
   assign o_bcd0  = r_bcd0;
   assign o_tick  = r_tick;
   assign o_carry = r_carry;

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// tb/tb_bcd_counter_2digit.sv - self-checking bench for bcd_counter_2digit

module tb_bcd_counter_2digit;

   logic       clk = 1'b0;
   logic       rn, en, up, ld;
   logic [7:0] d;

   logic [3:0] s_bcd1, s_bcd0, f_bcd1, f_bcd0;
   logic       s_tick, s_carry, f_tick, f_carry;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // slow instance: TICK_DIV=4
   bcd_counter_2digit #(.TICK_DIV(4)) u_slow (
      .i_clock(clk), .i_resetn(rn), .i_en(en), .i_up(up), .i_load(ld), .i_d(d),
      .o_bcd1(s_bcd1), .o_bcd0(s_bcd0), .o_tick(s_tick), .o_carry(s_carry)
   );

   // fast instance: TICK_DIV=1
   bcd_counter_2digit #(.TICK_DIV(1)) u_fast (
      .i_clock(clk), .i_resetn(rn), .i_en(en), .i_up(up), .i_load(ld), .i_d(d),
      .o_bcd1(f_bcd1), .o_bcd0(f_bcd0), .o_tick(f_tick), .o_carry(f_carry)
   );

   // Reference model: count kept as an integer 0..99, phase as enabled-cycle count.
   int m_cnt [2];
   int m_ph  [2];
   bit m_tick[2];
   bit m_carry[2];
   int m_div [2] = '{4, 1};

   function automatic int clampd(input int n);
      return (n > 9) ? 9 : n;
   endfunction

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         m_tick[k]  = 1'b0;
         m_carry[k] = 1'b0;
         if (!rn) begin
            m_cnt[k] = 0;
            m_ph[k]  = 0;
         end else if (ld) begin
            m_cnt[k] = clampd(int'(d[7:4])) * 10 + clampd(int'(d[3:0]));
            m_ph[k]  = 0;
         end else if (en) begin
            if (m_ph[k] == m_div[k] - 1) begin
               m_ph[k]   = 0;
               m_tick[k] = 1'b1;
               if (up) begin
                  m_carry[k] = (m_cnt[k] == 99);
                  m_cnt[k]   = (m_cnt[k] + 1) % 100;
               end else begin
                  m_carry[k] = (m_cnt[k] == 0);
                  m_cnt[k]   = (m_cnt[k] + 99) % 100;
               end
            end else begin
               m_ph[k] = m_ph[k] + 1;
            end
         end
      end
   endtask

   task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got bcd=%h tick=%b carry=%b, want bcd=%h tick=%b carry=%b",
                  nm, act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
      end
   endtask

   task automatic check_models(input string tag);
      logic [9:0] e;
      for (int k = 0; k < 2; k++) begin
         e = {4'(m_cnt[k] / 10), 4'(m_cnt[k] % 10), m_tick[k], m_carry[k]};
         if (k == 0) chk({tag, "/model4"}, {s_bcd1, s_bcd0, s_tick, s_carry}, e);
         else        chk({tag, "/model1"}, {f_bcd1, f_bcd0, f_tick, f_carry}, e);
      end
   endtask

   task automatic cyc(input bit r, input bit e, input bit u, input bit l,
                      input logic [7:0] dd, input string tag);
      rn = r; en = e; up = u; ld = l; d = dd;
      @(posedge clk);
      model_edge();
      #1;
      check_models(tag);
   endtask

   task automatic exp4(input string nm, input logic [7:0] b, input bit t, input bit c);
      chk(nm, {s_bcd1, s_bcd0, s_tick, s_carry}, {b, t, c});
   endtask

   task automatic exp1(input string nm, input logic [7:0] b, input bit t, input bit c);
      chk(nm, {f_bcd1, f_bcd0, f_tick, f_carry}, {b, t, c});
   endtask

   typedef struct {
      bit         rn, en, up, ld;
      logic [7:0] d;
      logic [7:0] e_bcd;
      bit         e_tick, e_carry;
   } vec_t;

   vec_t tbl[15];

   initial begin
      // Directed vectors for the TICK_DIV=1 instance, one row per clock edge.
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h98, 8'h98, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h99, 1'b1, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h98, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h09, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hFA, 8'h99, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h5C, 8'h59, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h60, 1'b1, 1'b0};

      rn = 1'b0; en = 1'b0; up = 1'b1; ld = 1'b0; d = 8'h00;

      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].rn, tbl[i].en, tbl[i].up, tbl[i].ld, tbl[i].d, $sformatf("row%0d", i));
         exp1($sformatf("row%0d", i), tbl[i].e_bcd, tbl[i].e_tick, tbl[i].e_carry);
      end

      // A: TICK_DIV=4 free count after reset, tick every 4th cycle
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "A_rst");
      exp4("A_rst", 8'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, $sformatf("A%0d", i));
         exp4($sformatf("A%0d", i), {4'h0, 4'(i / 4)}, (i % 4 == 0), 1'b0);
      end

      // B: enable gap freezes the prescaler
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "B_rst");
      for (int i = 1; i <= 9; i++) begin
         cyc(1'b1, (i <= 2 || i >= 8), 1'b1, 1'b0, 8'h00, $sformatf("B%0d", i));
         exp4($sformatf("B%0d", i), (i == 9) ? 8'h01 : 8'h00, (i == 9), 1'b0);
      end

      // C: clamped load, then load on the would-be step edge
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'hFA, "C_ld");
      exp4("C_ld", 8'h99, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, $sformatf("C_pre%0d", i));
      exp4("C_pre3", 8'h99, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h42, "C_ldstep");
      exp4("C_ldstep", 8'h42, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, $sformatf("C_post%0d", i));
         exp4($sformatf("C_post%0d", i), (i == 4) ? 8'h43 : 8'h42, (i == 4), 1'b0);
      end

      // D: reset beats load mid-count, partial prescale discarded
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h36, "D_ld");
      for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, $sformatf("D_up%0d", i));
      exp4("D_37", 8'h37, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "D_part");
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h55, "D_rst");
      exp4("D_rst", 8'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, $sformatf("D_post%0d", i));
         exp4($sformatf("D_post%0d", i), (i == 4) ? 8'h01 : 8'h00, (i == 4), 1'b0);
      end

      // Randomized run against the model, both instances
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 79) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 5) < 3), ($urandom_range(0, 24) == 0),
             8'($urandom), $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
